// File: rtl/jtdd_gfx_arb_pkg.sv
// Shared types for the graphics ROM arbiter: FSM states, slot indices,
// SDRAM address width and the round-robin helpers.
package jtdd_gfx_arb_pkg;

    localparam int unsigned SDRAM_AW = 22;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WAIT_ACK  = 2'd1,
        WAIT_DATA = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        SLOT_CHAR = 2'd0,
        SLOT_SCR  = 2'd1,
        SLOT_OBJ  = 2'd2
    } slot_t;

    // Successor in the char -> scr -> obj -> char rotation
    function automatic slot_t slot_next(input slot_t s);
        slot_t n;
        case (s)
            SLOT_CHAR: n = SLOT_SCR;
            SLOT_SCR:  n = SLOT_OBJ;
            default:   n = SLOT_CHAR;
        endcase
        return n;
    endfunction

    // First missing slot found when scanning the rotation from 'start'
    function automatic slot_t rr_pick(input logic [2:0] miss, input slot_t start);
        slot_t s;
        slot_t pick;
        logic  found;
        s     = start;
        pick  = start;
        found = 1'b0;
        for (int unsigned i = 0; i < 3; i++) begin
            if (!found && miss[s]) begin
                pick  = s;
                found = 1'b1;
            end
            s = slot_next(s);
        end
        return pick;
    endfunction

endpackage

// File: rtl/jtdd_gfx_arb_slot.sv
// One-entry read cache for a single graphics ROM requester.
// Hit when the cached word address matches the requester's current address.
module jtdd_gfx_slot
    import jtdd_gfx_arb_pkg::*;
#(
    parameter int unsigned AW = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [AW-1:0] i_addr,
    input  logic          i_fill,
    input  logic [AW-1:0] i_fill_addr,
    input  logic [15:0]   i_fill_data,
    output logic          o_ok,
    output logic [15:0]   o_data
);

    logic [AW-1:0] r_addr;
    logic [15:0]   r_data;
    logic          r_valid;

    // Capture the fetched word together with the address it was issued for
    always_ff @(posedge clk) begin
        if (rst) begin
            r_addr  <= '0;
            r_data  <= '0;
            r_valid <= 1'b0;
        end else if (i_fill) begin
            r_addr  <= i_fill_addr;
            r_data  <= i_fill_data;
            r_valid <= 1'b1;
        end
    end

    // Hit check against the live address, so a stale fill never reports ok
    always_comb begin
        o_ok   = r_valid && (r_addr == i_addr);
        o_data = r_data;
    end

endmodule

// File: rtl/jtdd_gfx_arb.sv
// Graphics ROM arbiter: char, scroll and object requesters share one SDRAM
// read port, each backed by a one-entry cache.
// Build option: JTDD_GFXARB_FIXPRIO_EN selects fixed priority obj > scr > char
// instead of round robin.
module jtdd_gfx_arb
    import jtdd_gfx_arb_pkg::*;
#(
    parameter logic [SDRAM_AW-1:0] CHAR_OFFSET = 22'h00000,
    parameter logic [SDRAM_AW-1:0] SCR_OFFSET  = 22'h08000,
    parameter logic [SDRAM_AW-1:0] OBJ_OFFSET  = 22'h20000
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [15:0]         char_addr,
    output logic [7:0]          char_data,
    output logic                char_ok,
    input  logic [16:0]         scr_addr,
    output logic [15:0]         scr_data,
    output logic                scr_ok,
    input  logic [18:0]         obj_addr,
    output logic [15:0]         obj_data,
    output logic                obj_ok,
    output logic [SDRAM_AW-1:0] sdram_addr,
    output logic                sdram_req,
    input  logic                sdram_ack,
    input  logic                sdram_dok,
    input  logic [15:0]         sdram_data
);

    state_t              r_state;
    slot_t               r_sel;
    logic                r_req;
    logic [SDRAM_AW-1:0] r_addr;
    logic [18:0]         r_fill_addr;
`ifndef JTDD_GFXARB_FIXPRIO_EN
    slot_t               r_rr;
`endif

    logic [14:0]         w_char_waddr;
    logic [15:0]         w_char_word;
    logic [2:0]          w_miss;
    logic                w_fill;
    slot_t               w_sel;
    logic [SDRAM_AW-1:0] w_req_addr;
    logic [18:0]         w_raw_addr;

    assign w_char_waddr = char_addr[15:1];

    // Ack and dok together in WAIT_ACK complete the transfer in one cycle
    assign w_fill = ((r_state == WAIT_DATA) && sdram_dok) ||
                    ((r_state == WAIT_ACK) && sdram_ack && sdram_dok);

    jtdd_gfx_slot #(.AW(15)) u_char (
        .clk         (clk),
        .rst         (rst),
        .i_addr      (w_char_waddr),
        .i_fill      (w_fill && (r_sel == SLOT_CHAR)),
        .i_fill_addr (r_fill_addr[14:0]),
        .i_fill_data (sdram_data),
        .o_ok        (char_ok),
        .o_data      (w_char_word)
    );

    jtdd_gfx_slot #(.AW(17)) u_scr (
        .clk         (clk),
        .rst         (rst),
        .i_addr      (scr_addr),
        .i_fill      (w_fill && (r_sel == SLOT_SCR)),
        .i_fill_addr (r_fill_addr[16:0]),
        .i_fill_data (sdram_data),
        .o_ok        (scr_ok),
        .o_data      (scr_data)
    );

    jtdd_gfx_slot #(.AW(19)) u_obj (
        .clk         (clk),
        .rst         (rst),
        .i_addr      (obj_addr),
        .i_fill      (w_fill && (r_sel == SLOT_OBJ)),
        .i_fill_addr (r_fill_addr),
        .i_fill_data (sdram_data),
        .o_ok        (obj_ok),
        .o_data      (obj_data)
    );

    // Byte lane picked by the live low address bit
    assign char_data  = char_addr[0] ? w_char_word[15:8] : w_char_word[7:0];
    assign w_miss     = {~obj_ok, ~scr_ok, ~char_ok};
    assign sdram_req  = r_req;
    assign sdram_addr = r_addr;

    // Choose which missing slot to serve next
    always_comb begin
`ifdef JTDD_GFXARB_FIXPRIO_EN
        if (w_miss[SLOT_OBJ])      w_sel = SLOT_OBJ;
        else if (w_miss[SLOT_SCR]) w_sel = SLOT_SCR;
        else                       w_sel = SLOT_CHAR;
`else
        w_sel = rr_pick(w_miss, r_rr);
`endif
    end

    // Unoffset word address and offset SDRAM address of the selected slot
    always_comb begin
        w_raw_addr = '0;
        w_req_addr = '0;
        case (w_sel)
            SLOT_CHAR: begin
                w_raw_addr = {4'd0, w_char_waddr};
                w_req_addr = CHAR_OFFSET + {7'd0, w_char_waddr};
            end
            SLOT_SCR: begin
                w_raw_addr = {2'd0, scr_addr};
                w_req_addr = SCR_OFFSET + {5'd0, scr_addr};
            end
            default: begin
                w_raw_addr = obj_addr;
                w_req_addr = OBJ_OFFSET + {3'd0, obj_addr};
            end
        endcase
    end

    // Request FSM: issue on a miss, hold until ack, return on data
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_sel       <= SLOT_CHAR;
            r_req       <= 1'b0;
            r_addr      <= '0;
            r_fill_addr <= '0;
`ifndef JTDD_GFXARB_FIXPRIO_EN
            r_rr        <= SLOT_CHAR;
`endif
        end else begin
            case (r_state)
                IDLE: begin
                    if (|w_miss) begin
                        r_sel       <= w_sel;
                        r_addr      <= w_req_addr;
                        r_fill_addr <= w_raw_addr;
                        r_req       <= 1'b1;
                        r_state     <= WAIT_ACK;
`ifndef JTDD_GFXARB_FIXPRIO_EN
                        r_rr        <= slot_next(w_sel);
`endif
                    end
                end
                WAIT_ACK: begin
                    if (sdram_ack) begin
                        r_req   <= 1'b0;
                        r_state <= sdram_dok ? IDLE : WAIT_DATA;
                    end
                end
                WAIT_DATA: begin
                    if (sdram_dok) r_state <= IDLE;
                end
                default: begin
                    r_req   <= 1'b0;
                    r_state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_jtdd_gfx_arb.sv
// Directed bench for jtdd_gfx_arb. Expected fetch order follows the build
// option JTDD_GFXARB_FIXPRIO_EN.
module tb_jtdd_gfx_arb;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] char_addr;
    logic [7:0]  char_data;
    logic        char_ok;
    logic [16:0] scr_addr;
    logic [15:0] scr_data;
    logic        scr_ok;
    logic [18:0] obj_addr;
    logic [15:0] obj_data;
    logic        obj_ok;
    logic [21:0] sdram_addr;
    logic        sdram_req;
    logic        sdram_ack;
    logic        sdram_dok;
    logic [15:0] sdram_data;

    // Second instance with a scroll offset that wraps the 22-bit space
    logic        w_rst;
    logic [7:0]  w_char_data;
    logic        w_char_ok;
    logic [15:0] w_scr_data;
    logic        w_scr_ok;
    logic [15:0] w_obj_data;
    logic        w_obj_ok;
    logic [21:0] w_addr;
    logic        w_req;
    logic        w_ack;
    logic        w_dok;
    logic [15:0] w_data;
    logic        w_seen_wrap;

    int n_checks = 0;
    int n_errors = 0;
    int ord [3];

    always #5 clk = ~clk;

    jtdd_gfx_arb u_dut (
        .clk        (clk),
        .rst        (rst),
        .char_addr  (char_addr),
        .char_data  (char_data),
        .char_ok    (char_ok),
        .scr_addr   (scr_addr),
        .scr_data   (scr_data),
        .scr_ok     (scr_ok),
        .obj_addr   (obj_addr),
        .obj_data   (obj_data),
        .obj_ok     (obj_ok),
        .sdram_addr (sdram_addr),
        .sdram_req  (sdram_req),
        .sdram_ack  (sdram_ack),
        .sdram_dok  (sdram_dok),
        .sdram_data (sdram_data)
    );

    jtdd_gfx_arb #(.SCR_OFFSET(22'h3FFFFF)) u_wrap (
        .clk        (clk),
        .rst        (w_rst),
        .char_addr  (16'h0000),
        .char_data  (w_char_data),
        .char_ok    (w_char_ok),
        .scr_addr   (17'h00002),
        .scr_data   (w_scr_data),
        .scr_ok     (w_scr_ok),
        .obj_addr   (19'h00000),
        .obj_data   (w_obj_data),
        .obj_ok     (w_obj_ok),
        .sdram_addr (w_addr),
        .sdram_req  (w_req),
        .sdram_ack  (w_ack),
        .sdram_dok  (w_dok),
        .sdram_data (w_data)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [21:0] exp_addr(input int s);
        case (s)
            0:       return {7'd0, char_addr[15:1]};
            1:       return 22'h008000 + {5'd0, scr_addr};
            default: return 22'h020000 + {3'd0, obj_addr};
        endcase
    endfunction

    function automatic logic get_ok(input int s);
        case (s)
            0:       return char_ok;
            1:       return scr_ok;
            default: return obj_ok;
        endcase
    endfunction

    task automatic chk_slot(input string tag, input int s, input logic [15:0] d);
        chk({tag, "_ok"}, 32'(get_ok(s)), 32'd1);
        case (s)
            0:       chk({tag, "_cdata"}, 32'(char_data), 32'(char_addr[0] ? d[15:8] : d[7:0]));
            1:       chk({tag, "_sdata"}, 32'(scr_data), 32'(d));
            default: chk({tag, "_odata"}, 32'(obj_data), 32'(d));
        endcase
    endtask

    task automatic do_reset;
        rst = 1'b1;
        tick;
        tick;
        rst = 1'b0;
    endtask

    // Serve one SDRAM read for slot s; optionally hold off ack, merge ack
    // with dok, or move obj_addr while the data is outstanding.
    task automatic fetch(input string tag, input int s, input logic [15:0] d,
                         input int hold, input bit both, input bit chg,
                         input logic [18:0] new_obj);
        logic [21:0] a;
        int n;
        n = 0;
        while (!sdram_req && n < 12) begin
            tick;
            n++;
        end
        chk({tag, "_req"}, 32'(sdram_req), 32'd1);
        a = exp_addr(s);
        chk({tag, "_addr"}, 32'(sdram_addr), 32'(a));
        for (int i = 0; i < hold; i++) begin
            tick;
            chk({tag, "_hold_req"}, 32'(sdram_req), 32'd1);
            chk({tag, "_hold_addr"}, 32'(sdram_addr), 32'(a));
        end
        if (both) begin
            sdram_ack  = 1'b1;
            sdram_dok  = 1'b1;
            sdram_data = d;
            tick;
            sdram_ack  = 1'b0;
            sdram_dok  = 1'b0;
        end else begin
            sdram_ack = 1'b1;
            tick;
            sdram_ack = 1'b0;
            chk({tag, "_ackdrop"}, 32'(sdram_req), 32'd0);
            if (chg) obj_addr = new_obj;
            sdram_dok  = 1'b1;
            sdram_data = d;
            tick;
            sdram_dok  = 1'b0;
        end
        chk({tag, "_donereq"}, 32'(sdram_req), 32'd0);
    endtask

    logic [15:0] dat [3];

    initial begin
`ifdef JTDD_GFXARB_FIXPRIO_EN
        ord[0] = 2; ord[1] = 1; ord[2] = 0;
`else
        ord[0] = 0; ord[1] = 1; ord[2] = 2;
`endif
        sdram_ack  = 1'b0;
        sdram_dok  = 1'b0;
        sdram_data = 16'h0000;

        // Test 1: reset values, first-fetch latency, byte select on hit
        char_addr = 16'h0003;
        scr_addr  = 17'h00010;
        obj_addr  = 19'h00100;
        dat[0] = 16'hA55A; dat[1] = 16'h1357; dat[2] = 16'h2468;
        do_reset;
        rst = 1'b1;
        chk("rst_char_ok", 32'(char_ok), 32'd0);
        chk("rst_scr_ok", 32'(scr_ok), 32'd0);
        chk("rst_obj_ok", 32'(obj_ok), 32'd0);
        chk("rst_char_data", 32'(char_data), 32'd0);
        chk("rst_scr_data", 32'(scr_data), 32'd0);
        chk("rst_obj_data", 32'(obj_data), 32'd0);
        chk("rst_req", 32'(sdram_req), 32'd0);
        chk("rst_addr", 32'(sdram_addr), 32'd0);
        rst = 1'b0;
        tick;
        chk("t1_latency_req", 32'(sdram_req), 32'd1);
        for (int k = 0; k < 3; k++) begin
            fetch("t1_fetch", ord[k], dat[ord[k]], 0, 1'b0, 1'b0, 19'h0);
            chk_slot("t1_slot", ord[k], dat[ord[k]]);
        end
        chk("t1_char_hi", 32'(char_data), 32'h0000_00A5);
        char_addr = 16'h0002;
        #1;
        chk("t1_char_ok_lo", 32'(char_ok), 32'd1);
        chk("t1_char_lo", 32'(char_data), 32'h0000_005A);
        sdram_ack = 1'b1;
        tick;
        sdram_ack = 1'b0;
        sdram_dok = 1'b1;
        sdram_data = 16'hDEAD;
        tick;
        sdram_dok = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick;
            chk("t1_no_req", 32'(sdram_req), 32'd0);
        end
        chk("t1_char_kept", 32'(char_data), 32'h0000_005A);

        // Test 2: simultaneous misses, last one completes with ack+dok together
        char_addr = 16'h0010;
        scr_addr  = 17'h00020;
        obj_addr  = 19'h00030;
        dat[0] = 16'h1234; dat[1] = 16'hBEEF; dat[2] = 16'hCAFE;
        do_reset;
        for (int k = 0; k < 3; k++) begin
            fetch("t2_fetch", ord[k], dat[ord[k]], 0, (k == 2), 1'b0, 19'h0);
            chk_slot("t2_slot", ord[k], dat[ord[k]]);
        end
        chk("t2_char_byte", 32'(char_data), 32'h0000_0034);
        tick;
        chk("t2_idle", 32'(sdram_req), 32'd0);

        // Test 3: obj address moves while its data is outstanding
        char_addr = 16'h0040;
        scr_addr  = 17'h00050;
        obj_addr  = 19'h00100;
        dat[0] = 16'h0F0F; dat[1] = 16'h3C3C;
        do_reset;
        for (int k = 0; k < 3; k++) begin
            if (ord[k] == 2) begin
                fetch("t3_stale", 2, 16'h1111, 0, 1'b0, 1'b1, 19'h00101);
                chk("t3_stale_ok", 32'(obj_ok), 32'd0);
                fetch("t3_refetch", 2, 16'h2222, 0, 1'b0, 1'b0, 19'h0);
                chk("t3_refetch_addr", 32'(exp_addr(2)), 32'h0002_0101);
                chk_slot("t3_obj", 2, 16'h2222);
            end else begin
                fetch("t3_fetch", ord[k], dat[ord[k]], 0, 1'b0, 1'b0, 19'h0);
                chk_slot("t3_slot", ord[k], dat[ord[k]]);
            end
        end

        // Test 4: reset during WAIT_DATA, late dok ignored
        char_addr = 16'h0100;
        scr_addr  = 17'h00200;
        obj_addr  = 19'h00300;
        do_reset;
        tick;
        chk("t4_req", 32'(sdram_req), 32'd1);
        sdram_ack = 1'b1;
        tick;
        sdram_ack = 1'b0;
        rst = 1'b1;
        tick;
        chk("t4_rst_req", 32'(sdram_req), 32'd0);
        chk("t4_rst_char_ok", 32'(char_ok), 32'd0);
        chk("t4_rst_scr_ok", 32'(scr_ok), 32'd0);
        chk("t4_rst_obj_ok", 32'(obj_ok), 32'd0);
        tick;
        rst = 1'b0;
        sdram_dok = 1'b1;
        sdram_data = 16'hFFFF;
        tick;
        sdram_dok = 1'b0;
        chk("t4_reissue_req", 32'(sdram_req), 32'd1);
        chk("t4_reissue_addr", 32'(sdram_addr), 32'(exp_addr(ord[0])));
        chk("t4_late_dok_ok", 32'(get_ok(ord[0])), 32'd0);
        fetch("t4_fetch", ord[0], 16'h7E81, 0, 1'b0, 1'b0, 19'h0);
        chk_slot("t4_slot", ord[0], 16'h7E81);

        // Test 5: ack held off for 20 cycles
        char_addr = 16'h0400;
        scr_addr  = 17'h00500;
        obj_addr  = 19'h00600;
        do_reset;
        fetch("t5_hold", ord[0], 16'h5555, 20, 1'b0, 1'b0, 19'h0);
        chk_slot("t5_slot", ord[0], 16'h5555);
        fetch("t5_next", ord[1], 16'h6666, 0, 1'b0, 1'b0, 19'h0);
        chk_slot("t5_next_slot", ord[1], 16'h6666);

        // Test 6: wrap-around instance has been served in the background
        for (int i = 0; i < 5; i++) tick;
        chk("t6_wrap_seen", 32'(w_seen_wrap), 32'd1);
        chk("t6_wrap_scr_ok", 32'(w_scr_ok), 32'd1);
        chk("t6_wrap_scr_data", 32'(w_scr_data), 32'h0000_0001);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    // Responder for the wrap instance: ack, then dok with data = addr[15:0]
    initial begin
        w_rst = 1'b1;
        w_ack = 1'b0;
        w_dok = 1'b0;
        w_data = 16'h0000;
        w_seen_wrap = 1'b0;
        repeat (3) tick;
        w_rst = 1'b0;
        forever begin
            tick;
            if (w_ack) begin
                w_ack  = 1'b0;
                w_dok  = 1'b1;
                w_data = w_addr[15:0];
            end else if (w_dok) begin
                w_dok = 1'b0;
            end else if (w_req) begin
                w_ack = 1'b1;
                if (w_addr == 22'h000001) w_seen_wrap = 1'b1;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "timeout");
    end

endmodule
